cwe_1280_reader: RTL and testbench

Password-gated read-side access controller for a lockable data register store; it is the reader counterpart to the team's password-gated writer blocks. It accepts a read request carrying an address and a 3-bit password, then evaluates the grant. Only in a later, separate state does it fetch from the external storage, so the data path never uses a stale grant decision. Repeated failed attempts place the block in a timed lockout. It sits between a requesting master (valid/ready) and a single-cycle-latency storage read port.

---
 rtl/cwe_1280_reader.sv | 138 +++++++++++++
 tb/tb_cwe_1280_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cwe_1280_reader.sv
// Password-gated read controller: latches a request, evaluates the grant in a
// dedicated CHECK state, fetches from storage only for granted reads, and locks out after repeated denials.
module cwe_1280_reader #(
    parameter int          DATA_W         = 8,
    parameter int          ADDR_W         = 2,
    parameter logic [2:0]  PASS           = 3'h4,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_password,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        WAIT,
        RESP,
        LOCKOUT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          pass_q, pass_d;
    logic [2:0]          fail_q, fail_d;
    logic [CNT_W-1:0]    lock_q, lock_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                grant;

    // Grant depends only on the password latched at acceptance, never on live inputs.
    assign grant = (pass_q == PASS) && (pass_q != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            lock_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    pass_d  = req_password;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (grant) begin
                    state_d = FETCH;
                end else begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    fail_d  = (fail_q == 3'(MAX_FAIL)) ? fail_q : fail_q + 3'd1;
                    state_d = RESP;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                data_d  = mem_rdata;
                err_d   = 1'b0;
                fail_d  = '0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (fail_q == 3'(MAX_FAIL)) begin
                        lock_d  = CNT_W'(LOCKOUT_CYCLES);
                        state_d = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                // Leaving when the counter reads 1 gives exactly LOCKOUT_CYCLES locked cycles.
                if (lock_q <= CNT_W'(1)) begin
                    lock_d  = '0;
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    lock_d  = lock_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign mem_rd_en = (state_q == FETCH);
    assign mem_addr  = addr_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign locked    = (state_q == LOCKOUT);

endmodule

// File: tb/tb_cwe_1280_reader.sv
// Self-checking bench for cwe_1280_reader: table of read transactions with a
// response scoreboard, plus hand-written reset and backpressure sequences.
module tb_cwe_1280_reader;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [2:0] req_password;
    logic       mem_rd_en;
    logic [1:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       locked;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4];
    logic [8:0] sbQueue [$];

    typedef struct {
        logic [1:0] addr;
        logic [2:0] pass;
        logic [7:0] expData;
        logic       expErr;
        logic       expLock;
        int         hold;
    } vec_t;

    vec_t vecs [12];

    cwe_1280_reader dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_password (req_password),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage model with one-cycle read latency; junk data outside read cycles.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 8'hEE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int         c;
        int         pulses;
        int         rdCycle;
        logic [1:0] rdAddr;
        logic [8:0] exp;
        logic [7:0] heldData;
        logic       heldErr;
        logic       stable;
        logic       lockOk;
        waitReady();
        sbQueue.push_back({v.expErr, v.expData});
        req_valid    = 1'b1;
        req_addr     = v.addr;
        req_password = v.pass;
        rsp_ready    = (v.hold == 0);
        tick();
        req_valid    = 1'b0;
        req_password = ~v.pass;
        req_addr     = ~v.addr;
        c       = 1;
        pulses  = 0;
        rdCycle = 0;
        rdAddr  = 2'd0;
        check("ready_low_in_check", 32'(req_ready), 32'd0);
        while (!rsp_valid && c < 12) begin
            if (mem_rd_en) begin
                pulses++;
                rdCycle = c;
                rdAddr  = mem_addr;
            end
            tick();
            c++;
        end
        check("rsp_latency", 32'(c), v.expErr ? 32'd2 : 32'd4);
        check("rd_pulses", 32'(pulses), v.expErr ? 32'd0 : 32'd1);
        if (!v.expErr) begin
            check("rd_cycle", 32'(rdCycle), 32'd2);
            check("rd_addr", 32'(rdAddr), 32'(v.addr));
        end
        if (sbQueue.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = sbQueue.pop_front();
            checkOutput(exp);
        end
        if (v.hold > 0) begin
            heldData = rsp_data;
            heldErr  = rsp_err;
            stable   = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                if (!rsp_valid || rsp_data !== heldData || rsp_err !== heldErr) stable = 1'b0;
            end
            check("backpressure_stable", 32'(stable), 32'd1);
            rsp_ready = 1'b1;
        end
        tick();
        rsp_ready = 1'b0;
        if (v.expLock) begin
            lockOk = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (!locked || req_ready) lockOk = 1'b0;
                req_valid    = 1'b1;
                req_addr     = 2'd2;
                req_password = 3'h4;
                tick();
            end
            req_valid = 1'b0;
            check("lockout_16_cycles", 32'(lockOk), 32'd1);
            check("lock_released", 32'({locked, req_ready, rsp_valid}), 32'b010);
        end else begin
            check("no_lock_after_rsp", 32'({locked, req_ready}), 32'b01);
        end
    endtask

    task automatic checkOutput(input logic [8:0] exp);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp[7:0]));
        check("rsp_err", 32'(rsp_err), 32'(exp[8]));
    endtask

    task automatic checkResetOutputs(input string name);
        check(name, 32'({req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, locked}), 32'd0);
    endtask

    initial begin
        logic quiet;
        mem[0] = 8'h3C;
        mem[1] = 8'h5A;
        mem[2] = 8'hA5;
        mem[3] = 8'hC3;

        vecs[0]  = '{2'd2, 3'h4, 8'hA5, 1'b0, 1'b0, 0};
        vecs[1]  = '{2'd1, 3'h3, 8'h00, 1'b1, 1'b0, 0};
        vecs[2]  = '{2'd3, 3'h0, 8'h00, 1'b1, 1'b0, 0};
        vecs[3]  = '{2'd3, 3'h4, 8'hC3, 1'b0, 1'b0, 0};
        vecs[4]  = '{2'd0, 3'h7, 8'h00, 1'b1, 1'b0, 0};
        vecs[5]  = '{2'd1, 3'h1, 8'h00, 1'b1, 1'b0, 0};
        vecs[6]  = '{2'd0, 3'h4, 8'h3C, 1'b0, 1'b0, 5};
        vecs[7]  = '{2'd0, 3'h2, 8'h00, 1'b1, 1'b0, 0};
        vecs[8]  = '{2'd2, 3'h5, 8'h00, 1'b1, 1'b0, 5};
        vecs[9]  = '{2'd3, 3'h6, 8'h00, 1'b1, 1'b1, 0};
        vecs[10] = '{2'd1, 3'h4, 8'h5A, 1'b0, 1'b0, 0};
        vecs[11] = '{2'd2, 3'h4, 8'hA5, 1'b0, 1'b0, 0};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 2'd0;
        req_password = 3'd0;
        rsp_ready    = 1'b0;
        tick();
        tick();
        checkResetOutputs("reset_outputs");
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Reset in the middle of a granted fetch; the in-flight response must vanish.
        waitReady();
        req_valid    = 1'b1;
        req_addr     = 2'd3;
        req_password = 3'h4;
        tick();
        req_valid = 1'b0;
        tick();
        check("fetch_before_reset", 32'(mem_rd_en), 32'd1);
        rst = 1'b1;
        #1;
        check("ready_low_in_reset", 32'(req_ready), 32'd0);
        tick();
        checkResetOutputs("reset_mid_fetch");
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_mid_reset", 32'(req_ready), 32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid || mem_rd_en) quiet = 1'b0;
        end
        check("no_rsp_after_reset", 32'(quiet), 32'd1);

        applyStimulus(vecs[10]);
        check("scoreboard_drained", 32'(sbQueue.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
